// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
//   Shared CPU definitions used by the fetch queue slice.
//   - CPU_AW / CPU_IW : default address and instruction widths
//   - NOP_INSTR       : instruction word presented when nothing valid is at the head
//   - fetch_entry_t   : {addr, instr} pair carried from fetch to decode
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

   localparam int CPU_AW = 32;
   localparam int CPU_IW = 32;

   localparam logic [CPU_IW-1:0] NOP_INSTR = 32'h0000_0000;

   typedef struct packed {
      logic [CPU_AW-1:0] addr;
      logic [CPU_IW-1:0] instr;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_ram.sv
// -----------------------------------------------------------------------------
// fetch_queue_ram
//   DEPTH x W register array backing the fetch queue.
//   One synchronous write port, one asynchronous read port; data is not reset.
// Ports:
//   clk    in   rising-edge clock
//   we     in   write enable
//   waddr  in   write index
//   wdata  in   write data
//   raddr  in   read index
//   rdata  out  mem[raddr], combinational
// -----------------------------------------------------------------------------
module fetch_queue_ram
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int W     = CPU_AW + CPU_IW,
   parameter int PW    = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          we,
   input  logic [PW-1:0] waddr,
   input  logic [W-1:0]  wdata,
   input  logic [PW-1:0] raddr,
   output logic [W-1:0]  rdata
);

   logic [W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
//   Prefetch buffer between fetch and decode. Stores {addr, instr} pairs in a
//   circular buffer and hands them to decode in order with valid/ready on both
//   sides. A taken branch (Flush) discards every entry so wrong-path
//   instructions never reach decode.
//
// Optional feature (macro FETCH_QUEUE_BYPASS_EN):
//   When defined and the queue is empty, a valid input (with Flush low) is
//   forwarded combinationally to the outputs. If decode takes it in that same
//   cycle it is never written; otherwise it is written normally.
//   When undefined, an entry is visible one cycle after it is pushed.
//
// Ports:
//   Clock      in   rising-edge clock
//   Reset      in   asynchronous, active-high; empties the queue
//   in_valid   in   fetch presents {in_addr, in_instr}
//   in_addr    in   PC of the instruction (stored unmodified)
//   in_instr   in   instruction word
//   in_ready   out  queue can accept this cycle (not full)
//   out_valid  out  head entry valid
//   out_addr   out  head PC (0 when nothing valid)
//   out_instr  out  head instruction (NOP when nothing valid)
//   out_ready  in   decode accepts the head this cycle
//   Flush      in   taken branch; discard all entries, higher priority than push/pop
//   count      out  occupancy 0..DEPTH
// -----------------------------------------------------------------------------
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int AW    = CPU_AW,
   parameter int IW    = CPU_IW
) (
   input  logic                     Clock,
   input  logic                     Reset,
   input  logic                     in_valid,
   input  logic [AW-1:0]            in_addr,
   input  logic [IW-1:0]            in_instr,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [AW-1:0]            out_addr,
   output logic [IW-1:0]            out_instr,
   input  logic                     out_ready,
   input  logic                     Flush,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam int EW = AW + IW;

   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic [CW-1:0] cnt_q;
   logic          stored_valid;
   logic          push;
   logic          pop;
   logic          wr_en;
   logic [EW-1:0] rd_data;
   logic [AW-1:0] head_addr;
   logic [IW-1:0] head_instr;

   assign in_ready     = (cnt_q != CW'(DEPTH));
   assign stored_valid = (cnt_q != '0);
   assign count        = cnt_q;

   // Only stored entries are popped; a bypassed entry never touched the array.
   assign pop = stored_valid & out_ready;

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;

   assign bypass     = ~stored_valid & in_valid & ~Flush;
   // A bypassed entry consumed by decode in the same cycle is not written.
   assign push       = in_valid & in_ready & ~(bypass & out_ready);
   assign out_valid  = stored_valid | bypass;
   assign head_addr  = bypass ? in_addr  : rd_data[EW-1:IW];
   assign head_instr = bypass ? in_instr : rd_data[IW-1:0];
`else
   assign push       = in_valid & in_ready;
   assign out_valid  = stored_valid;
   assign head_addr  = rd_data[EW-1:IW];
   assign head_instr = rd_data[IW-1:0];
`endif

   // Array contents are never reset, so mask the head when nothing is valid.
   // This also makes the outputs read 0 straight after reset.
   assign out_addr  = out_valid ? head_addr  : '0;
   assign out_instr = out_valid ? head_instr : IW'(NOP_INSTR);

   // A push coinciding with Flush is dropped.
   assign wr_en = push & ~Flush;

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else if (Flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         if (push && !pop) begin
            cnt_q <= cnt_q + CW'(1);
         end else if (pop && !push) begin
            cnt_q <= cnt_q - CW'(1);
         end
      end
   end

   fetch_queue_ram #(
      .DEPTH (DEPTH),
      .W     (EW),
      .PW    (PW)
   ) u_ram (
      .clk   (Clock),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata ({in_addr, in_instr}),
      .raddr (rd_ptr),
      .rdata (rd_data)
   );

endmodule

// File: tb/tb_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_fetch_queue
//   Self-checking bench for fetch_queue (DEPTH=4, AW=IW=32).
//   Table-driven vectors for fill/drain/wrap/flush plus hand-written sequences
//   for asynchronous reset and the same-cycle bypass path.
// -----------------------------------------------------------------------------
module tb_fetch_queue;

   logic        Clock;
   logic        Reset;
   logic        in_valid;
   logic [31:0] in_addr;
   logic [31:0] in_instr;
   logic        in_ready;
   logic        out_valid;
   logic [31:0] out_addr;
   logic [31:0] out_instr;
   logic        out_ready;
   logic        Flush;
   logic [2:0]  count;

   int checks;
   int failures;

   fetch_queue #(
      .DEPTH (4),
      .AW    (32),
      .IW    (32)
   ) dut (
      .Clock     (Clock),
      .Reset     (Reset),
      .in_valid  (in_valid),
      .in_addr   (in_addr),
      .in_instr  (in_instr),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_addr  (out_addr),
      .out_instr (out_instr),
      .out_ready (out_ready),
      .Flush     (Flush),
      .count     (count)
   );

   initial Clock = 1'b0;
   always #5 Clock = ~Clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        iv;
      logic [31:0] addr;
      logic [31:0] instr;
      logic        ordy;
      logic        fl;
      int          cnt;
      logic        ov;
      logic        ir;
      logic [31:0] oa;
      logic [31:0] oi;
      string       name;
   } vec_t;

   vec_t vecs[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic add(input string name, input logic iv, input logic [31:0] addr,
                      input logic [31:0] instr, input logic ordy, input logic fl,
                      input int cnt, input logic ov, input logic ir,
                      input logic [31:0] oa, input logic [31:0] oi);
      vec_t v;
      v.name = name; v.iv = iv; v.addr = addr; v.instr = instr; v.ordy = ordy;
      v.fl = fl; v.cnt = cnt; v.ov = ov; v.ir = ir; v.oa = oa; v.oi = oi;
      vecs.push_back(v);
   endtask

   task automatic idle_inputs();
      in_valid  = 1'b0;
      in_addr   = '0;
      in_instr  = '0;
      out_ready = 1'b0;
      Flush     = 1'b0;
   endtask

   // Drive one cycle of inputs, then return inputs to idle and settle.
   task automatic step(input logic iv, input logic [31:0] addr, input logic [31:0] instr,
                       input logic ordy, input logic fl);
      @(negedge Clock);
      in_valid  = iv;
      in_addr   = addr;
      in_instr  = instr;
      out_ready = ordy;
      Flush     = fl;
      @(posedge Clock);
      #1;
      idle_inputs();
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      idle_inputs();
      Reset = 1'b1;
      #1;
      chk("reset_count",     32'(count),     32'd0);
      chk("reset_out_valid", 32'(out_valid), 32'd0);
      chk("reset_in_ready",  32'(in_ready),  32'd1);
      chk("reset_out_addr",  out_addr,       32'h0);
      chk("reset_out_instr", out_instr,      32'h0);
      @(negedge Clock);
      Reset = 1'b0;

      // name, iv, addr, instr, ordy, fl -> cnt, ov, ir, head addr, head instr
      add("fill0",  1, 32'h0,   32'hA0, 0, 0, 1, 1, 1, 32'h0,   32'hA0);
      add("fill1",  1, 32'h4,   32'hA1, 0, 0, 2, 1, 1, 32'h0,   32'hA0);
      add("fill2",  1, 32'h8,   32'hA2, 0, 0, 3, 1, 1, 32'h0,   32'hA0);
      add("fill3",  1, 32'hC,   32'hA3, 0, 0, 4, 1, 0, 32'h0,   32'hA0);
      add("over",   1, 32'h10,  32'hA4, 0, 0, 4, 1, 0, 32'h0,   32'hA0);
      add("drain0", 0, 32'h0,   32'h0,  1, 0, 3, 1, 1, 32'h4,   32'hA1);
      add("drain1", 0, 32'h0,   32'h0,  1, 0, 2, 1, 1, 32'h8,   32'hA2);
      add("drain2", 0, 32'h0,   32'h0,  1, 0, 1, 1, 1, 32'hC,   32'hA3);
      add("drain3", 0, 32'h0,   32'h0,  1, 0, 0, 0, 1, 32'h0,   32'h0);
      add("pp_pre0",1, 32'h100, 32'hB0, 0, 0, 1, 1, 1, 32'h100, 32'hB0);
      add("pp_pre1",1, 32'h104, 32'hB1, 0, 0, 2, 1, 1, 32'h100, 32'hB0);
      for (int j = 1; j <= 6; j++) begin
         add($sformatf("pp%0d", j), 1, 32'h100 + 32'(4*(j+1)), 32'hB0 + 32'(j+1), 1, 0,
             2, 1, 1, 32'h100 + 32'(4*j), 32'hB0 + 32'(j));
      end
      add("pp_dr0", 0, 32'h0,   32'h0,  1, 0, 1, 1, 1, 32'h11C, 32'hB7);
      add("pp_dr1", 0, 32'h0,   32'h0,  1, 0, 0, 0, 1, 32'h0,   32'h0);
      add("fl_pre0",1, 32'h200, 32'hC0, 0, 0, 1, 1, 1, 32'h200, 32'hC0);
      add("fl_pre1",1, 32'h204, 32'hC1, 0, 0, 2, 1, 1, 32'h200, 32'hC0);
      add("fl_pre2",1, 32'h208, 32'hC2, 0, 0, 3, 1, 1, 32'h200, 32'hC0);
      add("flush",  1, 32'h0F0F0F0F, 32'hDD, 0, 1, 0, 0, 1, 32'h0, 32'h0);
      add("fl_push",1, 32'h0F0F0F0F, 32'hDD, 0, 0, 1, 1, 1, 32'h0F0F0F0F, 32'hDD);
      add("fl_pop", 1, 32'h300, 32'hEE, 1, 1, 0, 0, 1, 32'h0, 32'h0);
      add("empty_pop", 0, 32'h0, 32'h0, 1, 0, 0, 0, 1, 32'h0, 32'h0);

      foreach (vecs[i]) begin
         step(vecs[i].iv, vecs[i].addr, vecs[i].instr, vecs[i].ordy, vecs[i].fl);
         chk({vecs[i].name, "_count"},     32'(count),     32'(vecs[i].cnt));
         chk({vecs[i].name, "_out_valid"}, 32'(out_valid), 32'(vecs[i].ov));
         chk({vecs[i].name, "_in_ready"},  32'(in_ready),  32'(vecs[i].ir));
         if (vecs[i].ov) begin
            chk({vecs[i].name, "_out_addr"},  out_addr,  vecs[i].oa);
            chk({vecs[i].name, "_out_instr"}, out_instr, vecs[i].oi);
         end
      end

      // Asynchronous reset mid-operation: takes effect with no clock edge.
      step(1'b1, 32'h400, 32'hF0, 1'b0, 1'b0);
      step(1'b1, 32'h404, 32'hF1, 1'b0, 1'b0);
      chk("pre_areset_count", 32'(count), 32'd2);
      @(posedge Clock);
      #2;
      Reset = 1'b1;
      #1;
      chk("areset_count",     32'(count),     32'd0);
      chk("areset_out_valid", 32'(out_valid), 32'd0);
      chk("areset_in_ready",  32'(in_ready),  32'd1);
      chk("areset_out_addr",  out_addr,       32'h0);
      @(negedge Clock);
      Reset = 1'b0;

      // Empty queue, input valid, decode ready.
      @(negedge Clock);
      in_valid  = 1'b1;
      in_addr   = 32'h40;
      in_instr  = 32'hE0;
      out_ready = 1'b1;
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("byp_same_valid", 32'(out_valid), 32'd1);
      chk("byp_same_addr",  out_addr,       32'h40);
      chk("byp_same_instr", out_instr,      32'hE0);
`else
      chk("nobyp_same_valid", 32'(out_valid), 32'd0);
`endif
      @(posedge Clock);
      #1;
      idle_inputs();
      #1;
`ifdef FETCH_QUEUE_BYPASS_EN
      chk("byp_next_count", 32'(count),     32'd0);
      chk("byp_next_valid", 32'(out_valid), 32'd0);
`else
      chk("nobyp_next_count", 32'(count),     32'd1);
      chk("nobyp_next_valid", 32'(out_valid), 32'd1);
      chk("nobyp_next_addr",  out_addr,       32'h40);
      chk("nobyp_next_instr", out_instr,      32'hE0);
      step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
      chk("nobyp_pop_count",  32'(count),     32'd0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
